instr_fetch: RTL and testbench

Multicycle instruction fetch stage of the RV32 core. It holds the PC, issues one request at a time to instruction memory, and latches the returned word into the instruction register. Its `Instr` output drives the immediate extender and decoder directly downstream. It consumes the extender's `ExtendedImm` to compute taken-branch targets as `InstrPC + ExtendedImm`.

---
 rtl/instr_fetch_pkg.sv | 19 +
 rtl/instr_fetch_pc_next_calc.sv | 28 ++
 rtl/instr_fetch.sv | 109 ++++++++++
 tb/tb_instr_fetch.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/instr_fetch_pkg.sv
//------------------------------------------------------------------------------
// Module : instr_fetch_pkg
// Brief  : Shared constants for the instruction fetch stage (FSM codes, NOP, reset vector).
// Rev    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package instr_fetch_pkg;

    localparam logic [1:0]  c_ST_FETCH = 2'd0;
    localparam logic [1:0]  c_ST_WAIT  = 2'd1;
    localparam logic [1:0]  c_ST_FULL  = 2'd2;

    localparam logic [31:0] c_INSTR_NOP            = 32'h0000_0013;
    localparam logic [31:0] c_DEFAULT_RESET_VECTOR = 32'h0000_0000;

endpackage

`default_nettype wire

// File: rtl/instr_fetch_pc_next_calc.sv
//------------------------------------------------------------------------------
// Module : pc_next_calc
// Brief  : Combinational next-PC selection (sequential or branch) with misalign flag.
// Rev    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module pc_next_calc (
    input  logic [31:0] instr_pc_i,
    input  logic [31:0] ext_imm_i,
    input  logic        branch_taken_i,
    output logic [31:0] next_pc_o,
    output logic        misalign_o
);

    logic [31:0] w_target;
    logic [31:0] w_seq;

    assign w_target = instr_pc_i + ext_imm_i;
    assign w_seq    = instr_pc_i + 32'd4;

    // Branch targets are forced word-aligned; bit 1 is reported instead of honoured.
    assign next_pc_o  = branch_taken_i ? (w_target & 32'hFFFF_FFFC) : w_seq;
    assign misalign_o = branch_taken_i & w_target[1];

endmodule

`default_nettype wire

// File: rtl/instr_fetch.sv
//------------------------------------------------------------------------------
// Module : instr_fetch
// Brief  : Multicycle RV32 fetch stage: one outstanding request, instruction register.
// Rev    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module instr_fetch
    import instr_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = c_DEFAULT_RESET_VECTOR
) (
    input  logic        CLK,
    input  logic        Reset,
    output logic        IMemReq,
    output logic [31:0] IMemAddr,
    input  logic        IMemRValid,
    input  logic [31:0] IMemRData,
    output logic [31:0] Instr,
    output logic [31:0] InstrPC,
    output logic        InstrValid,
    input  logic        InstrAccept,
    input  logic        BranchTaken,
    input  logic [31:0] ExtendedImm,
    output logic        MisalignPulse
);

    logic [1:0]  state_q;
    logic [1:0]  state_d;
    logic [31:0] pc_q;
    logic [31:0] instr_q;
    logic [31:0] instr_pc_q;
    logic        misalign_q;

    logic [31:0] w_next_pc;
    logic        w_misalign;
    logic        w_capture;
    logic        w_accept;

    pc_next_calc u_pc_next_calc (
        .instr_pc_i     (instr_pc_q),
        .ext_imm_i      (ExtendedImm),
        .branch_taken_i (BranchTaken),
        .next_pc_o      (w_next_pc),
        .misalign_o     (w_misalign)
    );

    assign w_capture = (state_q == c_ST_WAIT) && IMemRValid;
    assign w_accept  = (state_q == c_ST_FULL) && InstrAccept;

    always_ff @(posedge CLK) begin
        if (Reset) begin
            state_q <= c_ST_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            c_ST_FETCH: state_d = c_ST_WAIT;
            c_ST_WAIT:  if (IMemRValid) state_d = c_ST_FULL;
            c_ST_FULL:  if (InstrAccept) state_d = c_ST_FETCH;
            default:    state_d = c_ST_FETCH;
        endcase
    end

    always_comb begin
        IMemReq    = 1'b0;
        InstrValid = 1'b0;
        case (state_q)
            c_ST_FETCH: IMemReq    = 1'b1;
            c_ST_FULL:  InstrValid = 1'b1;
            default: begin
                IMemReq    = 1'b0;
                InstrValid = 1'b0;
            end
        endcase
    end

    // Responses outside WAIT never reach the instruction register.
    always_ff @(posedge CLK) begin
        if (Reset) begin
            pc_q       <= RESET_PC;
            instr_q    <= c_INSTR_NOP;
            instr_pc_q <= 32'h0000_0000;
            misalign_q <= 1'b0;
        end else begin
            misalign_q <= 1'b0;
            if (w_capture) begin
                instr_q    <= IMemRData;
                instr_pc_q <= pc_q;
            end
            if (w_accept) begin
                pc_q       <= w_next_pc;
                misalign_q <= w_misalign;
            end
        end
    end

    assign IMemAddr      = pc_q;
    assign Instr         = instr_q;
    assign InstrPC       = instr_pc_q;
    assign MisalignPulse = misalign_q;

endmodule

`default_nettype wire

// File: tb/tb_instr_fetch.sv
//------------------------------------------------------------------------------
// Module : tb_instr_fetch
// Brief  : Randomized self-checking bench for instr_fetch against a transaction-level model.
// Rev    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_instr_fetch;

    logic        CLK = 1'b0;
    logic        Reset = 1'b1;
    logic        IMemReq;
    logic [31:0] IMemAddr;
    logic        IMemRValid = 1'b0;
    logic [31:0] IMemRData = 32'h0;
    logic [31:0] Instr;
    logic [31:0] InstrPC;
    logic        InstrValid;
    logic        InstrAccept = 1'b0;
    logic        BranchTaken = 1'b0;
    logic [31:0] ExtendedImm = 32'h0;
    logic        MisalignPulse;

    instr_fetch #(.RESET_PC(32'h0000_0000)) dut (
        .CLK           (CLK),
        .Reset         (Reset),
        .IMemReq       (IMemReq),
        .IMemAddr      (IMemAddr),
        .IMemRValid    (IMemRValid),
        .IMemRData     (IMemRData),
        .Instr         (Instr),
        .InstrPC       (InstrPC),
        .InstrValid    (InstrValid),
        .InstrAccept   (InstrAccept),
        .BranchTaken   (BranchTaken),
        .ExtendedImm   (ExtendedImm),
        .MisalignPulse (MisalignPulse)
    );

    always #5 CLK = ~CLK;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference model: where the stage is in its request/response/hand-off cycle.
    typedef enum int {PH_ISSUE, PH_AWAIT, PH_HOLD} phase_t;
    phase_t      m_ph;
    logic [31:0] m_pc, m_instr, m_ipc;
    bit          m_mis;
    bit          m_accepted;

    bit          pend = 0;
    int          resp_at = 0;
    int          cyc = 0;

    int          k_acc = 100;
    int          k_lat = 1;
    int          k_mode = 3;
    logic [31:0] k_val = 32'h0;
    bit          k_rst = 0;
    bit          k_stray = 0;

    function automatic void model_reset();
        m_ph    = PH_ISSUE;
        m_pc    = 32'h0000_0000;
        m_instr = 32'h0000_0013;
        m_ipc   = 32'h0000_0000;
        m_mis   = 0;
    endfunction

    task automatic step();
        logic        v, acc, tk;
        logic [31:0] d, imm, sum;
        int          lat;
        @(negedge CLK);
        check("IMemReq",       {31'b0, IMemReq},       {31'b0, m_ph == PH_ISSUE});
        check("IMemAddr",      IMemAddr,               m_pc);
        check("Instr",         Instr,                  m_instr);
        check("InstrPC",       InstrPC,                m_ipc);
        check("InstrValid",    {31'b0, InstrValid},    {31'b0, m_ph == PH_HOLD});
        check("MisalignPulse", {31'b0, MisalignPulse}, {31'b0, m_mis});

        if (m_ph == PH_ISSUE && !k_rst) begin
            lat     = (k_lat == 0) ? int'($urandom_range(1, 5)) : k_lat;
            pend    = 1;
            resp_at = cyc + lat;
        end

        v = 0;
        d = $urandom;
        if (pend && (k_rst || cyc == resp_at)) begin
            v    = 1;
            pend = 0;
        end else if (!pend && k_stray && $urandom_range(0, 3) == 0) begin
            v = 1;
        end

        acc = ($urandom_range(0, 99) < k_acc);
        tk  = 1'($urandom_range(0, 1));
        imm = $urandom;
        if (m_ph == PH_HOLD) begin
            case (k_mode)
                1: begin tk = 1; imm = k_val - m_ipc; end
                2: begin tk = 1; imm = k_val; end
                3: tk = 0;
                default: if ($urandom_range(0, 1) == 1) imm = 32'($urandom_range(0, 64)) - 32'd32;
            endcase
        end

        Reset       = k_rst;
        IMemRValid  = v;
        IMemRData   = d;
        InstrAccept = acc;
        BranchTaken = tk;
        ExtendedImm = imm;

        m_accepted = 0;
        if (k_rst) begin
            model_reset();
        end else begin
            m_mis = 0;
            case (m_ph)
                PH_ISSUE: m_ph = PH_AWAIT;
                PH_AWAIT: if (v) begin
                    m_instr = d;
                    m_ipc   = m_pc;
                    m_ph    = PH_HOLD;
                end
                PH_HOLD: if (acc) begin
                    sum = m_ipc + imm;
                    if (tk) begin
                        m_pc  = {sum[31:2], 2'b00};
                        m_mis = sum[1];
                    end else begin
                        m_pc = m_ipc + 32'd4;
                    end
                    m_ph       = PH_ISSUE;
                    m_accepted = 1;
                end
                default: m_ph = PH_ISSUE;
            endcase
        end
        cyc++;
    endtask

    task automatic run_instr();
        int n = 0;
        do begin
            step();
            n++;
        end while (!m_accepted && n < 60);
        if (!m_accepted) check("instr_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        model_reset();
        @(posedge CLK);
        k_rst = 1;
        step();
        k_rst = 0;

        // Back-to-back sequential fetches with 1-cycle memory
        repeat (3) run_instr();

        // Branch from 0x10 with imm -12 lands on 0x4
        k_mode = 1; k_val = 32'h0000_0010; run_instr();
        k_mode = 2; k_val = 32'hFFFF_FFF4; run_instr();
        k_mode = 3; run_instr();

        // Stall in FULL, then accept
        k_acc = 0;
        repeat (8) step();
        k_acc = 100;
        run_instr();

        // Slow memory with stray responses
        k_lat = 4; k_stray = 1;
        repeat (4) run_instr();

        // Misaligned target and address wrap
        k_lat = 1;
        k_mode = 1; k_val = 32'h0000_0008; run_instr();
        k_mode = 2; k_val = 32'h0000_0006; run_instr();
        k_mode = 1; k_val = 32'hFFFF_FFFC; run_instr();
        k_mode = 3; run_instr();
        run_instr();

        // Reset while a request is outstanding
        k_lat = 4;
        for (int i = 0; i < 20 && m_ph != PH_AWAIT; i++) step();
        step();
        k_rst = 1; step();
        k_rst = 0;
        repeat (2) run_instr();

        // Fully random traffic with occasional resets
        k_lat = 0; k_mode = 0; k_acc = 60; k_stray = 1;
        repeat (1500) begin
            k_rst = ($urandom_range(0, 99) == 0);
            step();
        end
        k_rst = 0;
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule

`default_nettype wire
